// File: rtl/vscale_dmem_bridge.sv
`timescale 1ns/1ps
// Bridges the vscale two-phase dmem port onto a single-outstanding valid/ready bus,
// with byte strobes, misalignment faulting and a response watchdog.
module vscale_dmem_bridge #(
  parameter int XPR_LEN        = 32,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_WIDTH      = 11
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               dmem_en,
  input  logic               dmem_wen,
  input  logic [2:0]         dmem_size,
  input  logic [XPR_LEN-1:0] dmem_addr,
  input  logic [XPR_LEN-1:0] dmem_wdata_delayed,
  output logic               dmem_wait,
  output logic [XPR_LEN-1:0] dmem_rdata,
  output logic               dmem_badmem_e,
  output logic               req_valid,
  input  logic               req_ready,
  output logic               req_write,
  output logic [XPR_LEN-1:0] req_addr,
  output logic [XPR_LEN-1:0] req_wdata,
  output logic [3:0]         req_wstrb,
  input  logic               resp_valid,
  input  logic [XPR_LEN-1:0] resp_rdata,
  input  logic               resp_error
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] DATA = 3'd1;
  localparam logic [2:0] REQ  = 3'd2;
  localparam logic [2:0] RESP = 3'd3;
  localparam logic [2:0] DONE = 3'd4;

  logic [2:0]           state;
  logic                 wen_q;
  logic [2:0]           size_q;
  logic [XPR_LEN-1:0]   addr_q;
  logic                 fault;
  logic [CNT_WIDTH-1:0] wdog;
  logic [CNT_WIDTH-1:0] wdog_next;
  logic                 misaligned;
  logic [3:0]           strobe;

  always_comb begin
    strobe     = 4'b1111;
    misaligned = 1'b0;
    case (size_q)
      3'd0: strobe = 4'b0001 << addr_q[1:0];
      3'd1: begin
        strobe     = 4'b0011 << {addr_q[1], 1'b0};
        misaligned = addr_q[0];
      end
      default: misaligned = (addr_q[1:0] != 2'b00);
    endcase
  end

  assign wdog_next     = wdog + 1'b1;
  assign dmem_wait     = (state == DATA) || (state == REQ) || (state == RESP);
  assign dmem_badmem_e = (state == DONE) && fault;
  assign req_valid     = (state == REQ);
  assign req_write     = wen_q;
  assign req_addr      = {addr_q[XPR_LEN-1:2], 2'b00};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      wen_q      <= 1'b0;
      size_q     <= '0;
      addr_q     <= '0;
      fault      <= 1'b0;
      wdog       <= '0;
      dmem_rdata <= '0;
      req_wdata  <= '0;
      req_wstrb  <= '0;
    end else begin
      case (state)
        // DONE doubles as an address phase so back-to-back accesses skip IDLE
        IDLE, DONE: begin
          fault <= 1'b0;
          if (dmem_en) begin
            wen_q  <= dmem_wen;
            size_q <= dmem_size;
            addr_q <= dmem_addr;
            state  <= DATA;
          end else begin
            state <= IDLE;
          end
        end
        DATA: begin
          if (misaligned) begin
            fault <= 1'b1;
            state <= DONE;
          end else begin
            if (wen_q) req_wdata <= dmem_wdata_delayed;
            req_wstrb <= wen_q ? strobe : 4'b0000;
            state     <= REQ;
          end
        end
        REQ: begin
          if (req_ready) begin
            wdog  <= '0;
            state <= RESP;
          end
        end
        RESP: begin
          if (resp_valid) begin
            if (!wen_q) dmem_rdata <= resp_rdata;
            fault <= resp_error;
            state <= DONE;
          end else if (wdog_next == CNT_WIDTH'(TIMEOUT_CYCLES)) begin
            wdog  <= wdog_next;
            fault <= 1'b1;
            state <= DONE;
          end else begin
            wdog <= wdog_next;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vscale_dmem_bridge.sv
`timescale 1ns/1ps
// Self-checking bench for vscale_dmem_bridge: directed scenarios plus randomized
// back-to-back traffic checked cycle by cycle against a timeline model.
module tb_vscale_dmem_bridge;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        dmem_en, dmem_wen;
  logic [2:0]  dmem_size;
  logic [31:0] dmem_addr, dmem_wdata_delayed;
  logic        dmem_wait, dmem_badmem_e;
  logic [31:0] dmem_rdata;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_wstrb;
  logic        resp_valid, resp_error;
  logic [31:0] resp_rdata;

  vscale_dmem_bridge #(.XPR_LEN(32), .TIMEOUT_CYCLES(TMO), .CNT_WIDTH(3)) dut (
    .clk(clk), .reset(reset),
    .dmem_en(dmem_en), .dmem_wen(dmem_wen), .dmem_size(dmem_size),
    .dmem_addr(dmem_addr), .dmem_wdata_delayed(dmem_wdata_delayed),
    .dmem_wait(dmem_wait), .dmem_rdata(dmem_rdata), .dmem_badmem_e(dmem_badmem_e),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_error(resp_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wen;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int unsigned rd;    // cycles req_ready is held low
    int unsigned rspd;  // RESP cycles before resp_valid; >= TMO means never
    logic        err;
    logic        spur;  // fire a resp_valid in the REQ handshake cycle
  } txn_t;

  txn_t        txq[$];
  int          total = 0;
  int          bad = 0;
  logic [31:0] m_rdata = '0;
  logic [31:0] m_wdata = '0;

  function automatic txn_t mk(logic wen, logic [2:0] size, logic [31:0] addr,
                              logic [31:0] wdata, logic [31:0] rdata,
                              int unsigned rd, int unsigned rspd, logic err);
    txn_t t;
    t.wen = wen; t.size = size; t.addr = addr; t.wdata = wdata; t.rdata = rdata;
    t.rd = rd; t.rspd = rspd; t.err = err; t.spur = 1'b0;
    return t;
  endfunction

  task automatic drive_addr(input txn_t t);
    dmem_en   = 1'b1;
    dmem_wen  = t.wen;
    dmem_size = t.size;
    dmem_addr = t.addr;
    dmem_wdata_delayed = $urandom;
  endtask

  // Runs every queued transaction back-to-back and checks all outputs each cycle.
  task automatic run_queue();
    int n;
    n = txq.size();
    @(negedge clk);
    drive_addr(txq[0]);
    for (int i = 0; i < n; i++) begin
      txn_t        t;
      logic        mis, tmo, exp_bad, exp_rv;
      int unsigned done_c;
      logic [3:0]  exp_strb;
      logic [31:0] exp_wdata;
      t   = txq[i];
      mis = (t.size == 3'd1 && t.addr % 2 == 1) || (t.size >= 3'd2 && t.addr % 4 != 0);
      tmo = t.rspd >= TMO;
      done_c = mis ? 2 : 3 + t.rd + (tmo ? TMO : t.rspd + 1);
      exp_bad = mis || tmo || t.err;
      if (!t.wen) exp_strb = 4'd0;
      else if (t.size == 3'd0) exp_strb = 4'(1 << (t.addr % 4));
      else if (t.size == 3'd1) exp_strb = 4'(3 << ((t.addr % 4) / 2 * 2));
      else exp_strb = 4'hF;
      exp_wdata = t.wen ? t.wdata : m_wdata;
      for (int unsigned c = 1; c <= done_c; c++) begin
        @(negedge clk);
        if (c == done_c && !mis && !tmo && !t.wen) m_rdata = t.rdata;
        exp_rv = !mis && c >= 2 && c <= 2 + t.rd;
        total++;
        if (dmem_wait !== (c != done_c)) begin
          bad++;
          $display("FAIL wait txn=%0d cyc=%0d got=%b exp=%b", i, c, dmem_wait, c != done_c);
        end
        total++;
        if (req_valid !== exp_rv) begin
          bad++;
          $display("FAIL req_valid txn=%0d cyc=%0d got=%b exp=%b", i, c, req_valid, exp_rv);
        end
        if (exp_rv) begin
          total++;
          if (req_addr !== (t.addr & 32'hFFFF_FFFC)) begin
            bad++;
            $display("FAIL req_addr txn=%0d got=%h exp=%h", i, req_addr, t.addr & 32'hFFFF_FFFC);
          end
          total++;
          if (req_write !== t.wen) begin
            bad++;
            $display("FAIL req_write txn=%0d got=%b exp=%b", i, req_write, t.wen);
          end
          total++;
          if (req_wstrb !== exp_strb) begin
            bad++;
            $display("FAIL req_wstrb txn=%0d got=%b exp=%b", i, req_wstrb, exp_strb);
          end
          total++;
          if (req_wdata !== exp_wdata) begin
            bad++;
            $display("FAIL req_wdata txn=%0d got=%h exp=%h", i, req_wdata, exp_wdata);
          end
        end
        total++;
        if (dmem_badmem_e !== (c == done_c ? exp_bad : 1'b0)) begin
          bad++;
          $display("FAIL badmem txn=%0d cyc=%0d got=%b exp=%b", i, c, dmem_badmem_e,
                   c == done_c ? exp_bad : 1'b0);
        end
        total++;
        if (dmem_rdata !== m_rdata) begin
          bad++;
          $display("FAIL rdata txn=%0d cyc=%0d got=%h exp=%h", i, c, dmem_rdata, m_rdata);
        end
        // stimulus for the cycle just observed
        if (c == 1) begin
          dmem_en = 1'b0;
          dmem_wdata_delayed = t.wdata;
          dmem_addr = $urandom;
          dmem_wen  = 1'($urandom);
          dmem_size = 3'($urandom);
        end
        req_ready  = !mis && (c == 2 + t.rd);
        resp_valid = 1'b0;
        resp_rdata = $urandom;
        resp_error = 1'($urandom);
        if (!mis && !tmo && c == 3 + t.rd + t.rspd) begin
          resp_valid = 1'b1;
          resp_rdata = t.rdata;
          resp_error = t.err;
        end else if (!mis && t.spur && c == 2 + t.rd) begin
          resp_valid = 1'b1;
        end
        if (c == done_c) begin
          if (i + 1 < n) drive_addr(txq[i + 1]);
          else dmem_en = 1'b0;
        end
      end
      if (!mis && t.wen) m_wdata = t.wdata;
    end
    txq.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    dmem_en = 1'b0; dmem_wen = 1'b0; dmem_size = 3'd0; dmem_addr = '0;
    dmem_wdata_delayed = '0; req_ready = 1'b0; resp_valid = 1'b0;
    resp_rdata = '0; resp_error = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if ({dmem_wait, dmem_badmem_e, req_valid, req_write} !== 4'b0) begin
      bad++;
      $display("FAIL reset_ctrl got=%b exp=0000", {dmem_wait, dmem_badmem_e, req_valid, req_write});
    end
    total++;
    if ({dmem_rdata, req_addr, req_wdata, req_wstrb} !== 100'b0) begin
      bad++;
      $display("FAIL reset_data got=%h/%h/%h/%h exp=0", dmem_rdata, req_addr, req_wdata, req_wstrb);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_word_load();
    txq.push_back(mk(1'b0, 3'd2, 32'h100, 32'h0, 32'hDEAD_BEEF, 0, 0, 1'b0));
    run_queue();
    total++;
    if (dmem_rdata !== 32'hDEAD_BEEF) begin
      bad++;
      $display("FAIL word_load_data got=%h exp=%h", dmem_rdata, 32'hDEAD_BEEF);
    end
    @(negedge clk);
  endtask

  task automatic test_byte_store();
    txq.push_back(mk(1'b1, 3'd0, 32'h203, 32'h5A5A_5A5A, 32'h1234_5678, 3, 1, 1'b0));
    run_queue();
    total++;
    if (req_wdata !== 32'h5A5A_5A5A) begin
      bad++;
      $display("FAIL byte_store_wdata got=%h exp=%h", req_wdata, 32'h5A5A_5A5A);
    end
    @(negedge clk);
  endtask

  task automatic test_misaligned();
    txq.push_back(mk(1'b0, 3'd1, 32'h101, 32'h0, 32'hAAAA_AAAA, 0, 0, 1'b0));
    run_queue();
    total++;
    if (dmem_badmem_e !== 1'b1) begin
      bad++;
      $display("FAIL mis_half got=%b exp=1", dmem_badmem_e);
    end
    @(negedge clk);
    txq.push_back(mk(1'b1, 3'd2, 32'h102, 32'h7777_7777, 32'h0, 0, 0, 1'b0));
    run_queue();
    total++;
    if (dmem_badmem_e !== 1'b1) begin
      bad++;
      $display("FAIL mis_word got=%b exp=1", dmem_badmem_e);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    txq.push_back(mk(1'b0, 3'd2, 32'h400, 32'h0, 32'h1111_2222, 0, 0, 1'b0));
    txq.push_back(mk(1'b0, 3'd1, 32'h406, 32'h0, 32'h3333_4444, 1, 2, 1'b0));
    run_queue();
    total++;
    if (dmem_rdata !== 32'h3333_4444) begin
      bad++;
      $display("FAIL b2b_data got=%h exp=%h", dmem_rdata, 32'h3333_4444);
    end
    @(negedge clk);
  endtask

  task automatic test_faults();
    logic [31:0] held;
    txq.push_back(mk(1'b0, 3'd2, 32'h500, 32'h0, 32'hBAD0_0001, 0, 1, 1'b1));
    run_queue();
    @(negedge clk);
    txq.push_back(mk(1'b0, 3'd2, 32'h504, 32'h0, 32'hBAD0_0002, 1, 10, 1'b0));
    run_queue();
    total++;
    if (dmem_badmem_e !== 1'b1) begin
      bad++;
      $display("FAIL timeout_bad got=%b exp=1", dmem_badmem_e);
    end
    held = m_rdata;
    @(negedge clk);
    resp_valid = 1'b1; resp_rdata = 32'hFEED_FACE; resp_error = 1'b1;
    @(negedge clk);
    resp_valid = 1'b0;
    total++;
    if ({dmem_wait, dmem_badmem_e, req_valid} !== 3'b000) begin
      bad++;
      $display("FAIL late_resp_ctrl got=%b exp=000", {dmem_wait, dmem_badmem_e, req_valid});
    end
    total++;
    if (dmem_rdata !== held) begin
      bad++;
      $display("FAIL late_resp_data got=%h exp=%h", dmem_rdata, held);
    end
    txq.push_back(mk(1'b0, 3'd0, 32'h50B, 32'h0, 32'h0BAD_F00D, 0, 0, 1'b0));
    run_queue();
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    txn_t t;
    t = mk(1'b1, 3'd2, 32'h600, 32'hCAFE_0000, 32'h0, 5, 0, 1'b0);
    @(negedge clk);
    drive_addr(t);
    @(negedge clk);
    dmem_en = 1'b0;
    dmem_wdata_delayed = t.wdata;
    @(negedge clk);
    total++;
    if (req_valid !== 1'b1) begin
      bad++;
      $display("FAIL mid_req_valid got=%b exp=1", req_valid);
    end
    #2 reset = 1'b1;
    #1;
    total++;
    if ({req_valid, dmem_wait} !== 2'b00) begin
      bad++;
      $display("FAIL async_reset got=%b exp=00", {req_valid, dmem_wait});
    end
    total++;
    if ({req_addr, req_wdata, req_wstrb} !== 68'b0) begin
      bad++;
      $display("FAIL async_reset_fields got=%h/%h/%h exp=0", req_addr, req_wdata, req_wstrb);
    end
    m_rdata = '0;
    m_wdata = '0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    txq.push_back(mk(1'b0, 3'd2, 32'h604, 32'h0, 32'h9876_5432, 0, 0, 1'b0));
    run_queue();
    @(negedge clk);
  endtask

  task automatic test_random();
    for (int g = 0; g < 8; g++) begin
      int k;
      k = int'($urandom_range(1, 5));
      for (int j = 0; j < k; j++) begin
        txn_t t;
        t.wen   = 1'($urandom);
        t.size  = 3'($urandom_range(0, 4));
        t.addr  = $urandom;
        t.wdata = $urandom;
        t.rdata = $urandom;
        t.rd    = $urandom_range(0, 3);
        t.rspd  = $urandom_range(0, 5);
        t.err   = ($urandom_range(0, 7) == 0);
        t.spur  = 1'($urandom);
        txq.push_back(t);
      end
      run_queue();
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_word_load();
    test_byte_store();
    test_misaligned();
    test_back_to_back();
    test_faults();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vscale_dmem_bridge.md
Name: vscale_dmem_bridge

Overview:
- Sits directly downstream of the vscale pipeline's data-memory port.
- Converts the pipeline's two-phase dmem protocol into a single-outstanding valid/ready request/response bus toward the data memory or interconnect. The two phases are address in cycle N and write data in cycle N+1, with a wait-based stall.
- Generates byte strobes and detects misaligned accesses.
- Applies a response watchdog and reports faults on dmem_badmem_e.

Parameters:
- XPR_LEN, 32, data and address width.
- TIMEOUT_CYCLES, 1024, maximum cycles spent in RESP before a forced bus-error completion; minimum 2.
- CNT_WIDTH, 11, watchdog counter width; must satisfy 2^CNT_WIDTH > TIMEOUT_CYCLES.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- dmem_en  in  1  address-phase valid from pipeline
- dmem_wen  in  1  1 = store, 0 = load
- dmem_size  in  3  0 = byte, 1 = half, 2 = word; other codes treated as word
- dmem_addr  in  XPR_LEN  byte address (address phase)
- dmem_wdata_delayed  in  XPR_LEN  store data, valid in the cycle after the address phase; already byte-replicated
- dmem_wait  out  1  stall to pipeline
- dmem_rdata  out  XPR_LEN  raw aligned load word
- dmem_badmem_e  out  1  access fault, valid only when the completion cycle is signalled
- req_valid  out  1  bus request valid
- req_ready  in  1  bus request accept
- req_write  out  1  store request
- req_addr  out  XPR_LEN  dmem_addr with bits [1:0] forced to 0
- req_wdata  out  XPR_LEN  store data
- req_wstrb  out  4  byte enables; 0 for loads
- resp_valid  in  1  bus response valid, single-cycle pulse
- resp_rdata  in  XPR_LEN  load data
- resp_error  in  1  bus error qualifier for resp_valid

Behaviour:

Reset:
- Asynchronous, active-high; all state clears immediately.
- Outputs on reset: FSM = IDLE, dmem_wait = 0, dmem_rdata = 0, dmem_badmem_e = 0, req_valid = 0, req_write = 0, req_addr = 0, req_wdata = 0, req_wstrb = 0, watchdog = 0.
- Reset mid-transaction abandons the request: req_valid drops immediately.
- Any resp_valid arriving in IDLE is ignored.

FSM states: IDLE, DATA, REQ, RESP, DONE.
- dmem_wait = 1 in DATA, REQ and RESP; 0 in IDLE and DONE. Derived from registered state.
- IDLE or DONE with dmem_en = 1: capture wen, size and addr, then go to DATA. DONE accepting a new request is the pipelined back-to-back case.
- IDLE or DONE with dmem_en = 0: go to IDLE.
- DATA, aligned access: capture dmem_wdata_delayed into req_wdata (stores only), compute req_wstrb, go to REQ.
- DATA, misaligned access (half with addr[0] = 1, or word with addr[1:0] != 0): go straight to DONE with fault = 1. No bus request is issued.
- REQ: req_valid = 1 with registered fields held stable until req_ready = 1, then go to RESP and clear the watchdog. No timeout applies in REQ.
- RESP:
  - resp_valid = 1: capture resp_rdata (loads only; dmem_rdata is unchanged on stores), set fault = resp_error, go to DONE.
  - Otherwise the watchdog increments. When it reaches TIMEOUT_CYCLES, go to DONE with fault = 1.
  - A resp_valid sampled in the same cycle as the REQ handshake is not accepted.
- DONE: exactly one cycle. dmem_wait = 0, dmem_badmem_e = fault, dmem_rdata is valid. fault is cleared on leaving DONE.

Strobes:
- Byte: 4'b0001 << addr[1:0].
- Half: 4'b0011 << {addr[1], 1'b0}.
- Word: 4'b1111.

Outputs outside DONE:
- dmem_badmem_e = 0 in every other state.
- dmem_rdata holds its last captured value.

Latency:
- Minimum load or store: address phase in cycle N; DATA at N+1; REQ at N+2 with req_ready = 1; resp_valid at N+3; DONE at N+4 (dmem_wait low, data valid).
- Misaligned access: DONE at N+2.

Test Plan:
- Aligned word load: addr = 0x100, size = 2, req_ready and resp_valid with zero wait, resp_rdata = 0xDEADBEEF -> req_addr = 0x100, req_wstrb = 0, dmem_wait high for cycles N+1 to N+3, dmem_rdata = 0xDEADBEEF and badmem = 0 at N+4.
- Byte store: addr = 0x203, size = 0, wdata = 0x5A5A5A5A -> req_write = 1, req_addr = 0x200, req_wstrb = 4'b1000, req_wdata = 0x5A5A5A5A; req_ready held low for 3 cycles -> req_valid and all fields stable throughout.
- Misaligned accesses: half at 0x101, then word at 0x102 -> no req_valid ever asserted; each completes at N+2 with dmem_badmem_e = 1.
- Back-to-back: new dmem_en presented in the DONE cycle of a prior load -> second request is captured and issued without an IDLE cycle; both return correct data.
- Faults:
  - resp_error = 1 -> DONE with badmem = 1.
  - With TIMEOUT_CYCLES = 4 and no resp_valid -> DONE after 4 RESP cycles with badmem = 1.
  - A subsequent late resp_valid arriving in IDLE -> ignored.
- Reset asserted while in REQ -> req_valid = 0 and dmem_wait = 0 immediately (asynchronous, no clock edge needed); after release the FSM is in IDLE and a new load completes normally.
